// File: rtl/text_mode_pixel_pipe.sv
// rtl/text_mode_pixel_pipe.sv - 640x480 text-mode raster generator with 3-stage VRAM/font pixel pipeline
module text_mode_pixel_pipe #(
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 752,
    parameter int H_TOTAL      = 800,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 492,
    parameter int V_TOTAL      = 525
) (
    input  logic        Clk,
    input  logic        reset_rtl_0,
    output logic [9:0]  vram_addr,
    input  logic [31:0] vram_rdata,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_rdata,
    input  logic [11:0] fg_rgb,
    input  logic [11:0] bg_rgb,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        vde
);

    logic [9:0]  hc_q, hc_d, vc_q, vc_d;
    logic        s0_hs, s0_vs, s0_de;
    logic [4:0]  s1_hc_q;
    logic [3:0]  s1_vrow_q;
    logic        s1_hs_q, s1_vs_q, s1_de_q;
    logic [7:0]  s1_char;
    logic [2:0]  s2_hc_q;
    logic        s2_inv_q, s2_hs_q, s2_vs_q, s2_de_q;
    logic        s2_pix;
    logic [11:0] rgb_q, rgb_d;
    logic        hsync_q, vsync_q, vde_q;

    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == 10'(H_TOTAL - 1)) begin
            hc_d = 10'd0;
            vc_d = (vc_q == 10'(V_TOTAL - 1)) ? 10'd0 : vc_q + 10'd1;
        end
    end

    assign s0_hs = ~((hc_q >= 10'(H_SYNC_START)) && (hc_q < 10'(H_SYNC_END)));
    assign s0_vs = ~((vc_q >= 10'(V_SYNC_START)) && (vc_q < 10'(V_SYNC_END)));
    assign s0_de = (hc_q < 10'(H_ACTIVE)) && (vc_q < 10'(V_ACTIVE));

    // 20 words per text row: row*20 = row*16 + row*4, no multiplier needed
    assign vram_addr = {1'b0, vc_q[8:4], 4'b0000}
                     + {3'b000, vc_q[8:4], 2'b00}
                     + {5'b00000, hc_q[9:5]};

    assign s1_char = vram_rdata[{s1_hc_q[4:3], 3'b000} +: 8];

    // Gated so the ROM sees row 0 of glyph 0 while the VRAM word is still arbitrary in reset
    assign font_addr = reset_rtl_0 ? {s1_char[6:0], s1_vrow_q} : 11'h000;

    assign s2_pix = font_rdata[3'd7 - s2_hc_q] ^ s2_inv_q;
    assign rgb_d  = s2_de_q ? (s2_pix ? fg_rgb : bg_rgb) : 12'h000;

    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            hc_q      <= 10'd0;
            vc_q      <= 10'd0;
            s1_hc_q   <= 5'd0;
            s1_vrow_q <= 4'd0;
            s1_hs_q   <= 1'b1;
            s1_vs_q   <= 1'b1;
            s1_de_q   <= 1'b0;
            s2_hc_q   <= 3'd0;
            s2_inv_q  <= 1'b0;
            s2_hs_q   <= 1'b1;
            s2_vs_q   <= 1'b1;
            s2_de_q   <= 1'b0;
            rgb_q     <= 12'h000;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            vde_q     <= 1'b0;
        end else begin
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            s1_hc_q   <= hc_q[4:0];
            s1_vrow_q <= vc_q[3:0];
            s1_hs_q   <= s0_hs;
            s1_vs_q   <= s0_vs;
            s1_de_q   <= s0_de;
            s2_hc_q   <= s1_hc_q[2:0];
            s2_inv_q  <= s1_char[7];
            s2_hs_q   <= s1_hs_q;
            s2_vs_q   <= s1_vs_q;
            s2_de_q   <= s1_de_q;
            rgb_q     <= rgb_d;
            hsync_q   <= s2_hs_q;
            vsync_q   <= s2_vs_q;
            vde_q     <= s2_de_q;
        end
    end

    assign red   = rgb_q[11:8];
    assign green = rgb_q[7:4];
    assign blue  = rgb_q[3:0];
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign vde   = vde_q;

endmodule

// File: tb/tb_text_mode_pixel_pipe.sv
// tb/tb_text_mode_pixel_pipe.sv - directed checks of raster timing, glyph rendering and reset
module tb_text_mode_pixel_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  vram_addr;
    logic [31:0] vram_rdata;
    logic [10:0] font_addr;
    logic [7:0]  font_rdata;
    logic [11:0] fg, bg;
    logic [3:0]  red, green, blue;
    logic        hsync, vsync, vde;
    logic [11:0] rgb;

    logic [9:0]  s_vram_addr;
    logic [10:0] s_font_addr;
    logic [3:0]  s_red, s_green, s_blue;
    logic        s_hsync, s_vsync, s_vde;

    logic [31:0] vram [0:1023];
    logic [7:0]  font [0:2047];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    localparam logic [11:0] F = 12'hFFF;
    localparam logic [11:0] B = 12'h00F;

    always #20 clk = ~clk;

    text_mode_pixel_pipe u_dut (
        .Clk         (clk),
        .reset_rtl_0 (rst_n),
        .vram_addr   (vram_addr),
        .vram_rdata  (vram_rdata),
        .font_addr   (font_addr),
        .font_rdata  (font_rdata),
        .fg_rgb      (fg),
        .bg_rgb      (bg),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hsync       (hsync),
        .vsync       (vsync),
        .vde         (vde)
    );

    // Short-frame instance so vsync and frame wrap fit in a short run
    text_mode_pixel_pipe #(
        .V_ACTIVE     (8),
        .V_SYNC_START (10),
        .V_SYNC_END   (12),
        .V_TOTAL      (15)
    ) u_dut_small (
        .Clk         (clk),
        .reset_rtl_0 (rst_n),
        .vram_addr   (s_vram_addr),
        .vram_rdata  (32'h0),
        .font_addr   (s_font_addr),
        .font_rdata  (8'h00),
        .fg_rgb      (fg),
        .bg_rgb      (bg),
        .red         (s_red),
        .green       (s_green),
        .blue        (s_blue),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .vde         (s_vde)
    );

    assign rgb = {red, green, blue};

    always @(posedge clk) begin
        vram_rdata <= vram[vram_addr];
        font_rdata <= font[font_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        logic [7:0] pat;
        rst_n = 1'b0;
        fg    = F;
        bg    = B;
        for (int i = 0; i < 1024; i++) vram[i] = 32'h0;
        for (int i = 0; i < 2048; i++) font[i] = 8'h00;
        vram[0]        = 32'h0000_0041;
        vram[1]        = 32'h0000_C100;
        vram[39]       = 32'h4200_0000;
        font[11'h410]  = 8'h18;
        font[11'h42F]  = 8'h01;

        repeat (5) begin
            @(posedge clk);
            #1;
            check("rst_hsync", 32'(hsync), 32'd1);
            check("rst_vsync", 32'(vsync), 32'd1);
            check("rst_vde",   32'(vde),   32'd0);
            check("rst_rgb",   32'(rgb),   32'h0);
            check("rst_font_addr", 32'(font_addr), 32'h0);
            check("rst_vram_addr", 32'(vram_addr), 32'h0);
        end
        rst_n = 1'b1;
        cyc   = 0;

        check("vram_addr_n0", 32'(vram_addr), 32'd0);
        run_to(1);  check("font_addr_A", 32'(font_addr), 32'h410);
                    check("vde_n1", 32'(vde), 32'd0);
        run_to(2);  check("vde_n2", 32'(vde), 32'd0);

        pat = 8'h18;
        for (int i = 0; i < 8; i++) begin
            run_to(3 + i);
            check($sformatf("vde_px%0d", i), 32'(vde), 32'd1);
            check($sformatf("glyph_px%0d", i), 32'(rgb), 32'(pat[7 - i] ? F : B));
        end

        run_to(32); check("vram_addr_hc32", 32'(vram_addr), 32'd1);
        run_to(33); check("font_addr_blank", 32'(font_addr), 32'h000);
        run_to(41); check("font_addr_byte1", 32'(font_addr), 32'h410);
        for (int i = 0; i < 8; i++) begin
            run_to(43 + i);
            check($sformatf("inv_px%0d", 40 + i), 32'(rgb), 32'(pat[7 - i] ? B : F));
        end

        run_to(642);  check("vde_last",   32'(vde),   32'd1);
        run_to(643);  check("vde_off",    32'(vde),   32'd0);
                      check("rgb_blank",  32'(rgb),   32'h0);
        run_to(658);  check("hs_pre",     32'(hsync), 32'd1);
        run_to(659);  check("hs_start",   32'(hsync), 32'd0);
        run_to(754);  check("hs_end",     32'(hsync), 32'd0);
        run_to(755);  check("hs_after",   32'(hsync), 32'd1);
                      check("vs_line0",   32'(vsync), 32'd1);
        run_to(803);  check("vde_line1",  32'(vde),   32'd1);
        run_to(1458); check("hs_l1_pre",  32'(hsync), 32'd1);
        run_to(1459); check("hs_l1_start",32'(hsync), 32'd0);

        run_to(5603);  check("s_vde_l7",     32'(s_vde),   32'd1);
        run_to(6403);  check("s_vde_l8",     32'(s_vde),   32'd0);
        run_to(8002);  check("s_vs_pre",     32'(s_vsync), 32'd1);
        run_to(8003);  check("s_vs_start",   32'(s_vsync), 32'd0);
        run_to(9602);  check("s_vs_end",     32'(s_vsync), 32'd0);
        run_to(9603);  check("s_vs_after",   32'(s_vsync), 32'd1);
        run_to(12002); check("s_vde_wrap_pre", 32'(s_vde), 32'd0);
        run_to(12003); check("s_vde_wrap",   32'(s_vde),   32'd1);
        run_to(12800); check("vram_addr_row1", 32'(vram_addr), 32'd20);
        run_to(20002); check("s_vs2_pre",    32'(s_vsync), 32'd1);
        run_to(20003); check("s_vs2_start",  32'(s_vsync), 32'd0);
        run_to(21602); check("s_vs2_end",    32'(s_vsync), 32'd0);
        run_to(21603); check("s_vs2_after",  32'(s_vsync), 32'd1);

        run_to(25439); check("vram_addr_end", 32'(vram_addr), 32'd39);
        run_to(25440); check("font_addr_end", 32'(font_addr), 32'h42F);
        run_to(25441); check("px638",         32'(rgb),       32'(B));
        run_to(25442); check("px639",         32'(rgb),       32'(F));
        run_to(25443); check("px640_vde",     32'(vde),       32'd0);
                       check("px640_rgb",     32'(rgb),       32'h0);

        run_to(25900);
        check("pre_rst_vde", 32'(vde), 32'd1);
        check("pre_rst_rgb", 32'(rgb), 32'(B));
        rst_n = 1'b0;
        #1;
        check("mid_rst_vde",   32'(vde),   32'd0);
        check("mid_rst_hsync", 32'(hsync), 32'd1);
        check("mid_rst_vsync", 32'(vsync), 32'd1);
        check("mid_rst_rgb",   32'(rgb),   32'h0);
        check("mid_rst_vram",  32'(vram_addr), 32'h0);
        check("mid_rst_font",  32'(font_addr), 32'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("mid_rst_hold_vde", 32'(vde), 32'd0);
        end
        rst_n = 1'b1;
        cyc   = 0;
        run_to(1);   check("re_font_addr", 32'(font_addr), 32'h410);
        run_to(2);   check("re_vde_n2",    32'(vde),   32'd0);
        run_to(3);   check("re_vde_n3",    32'(vde),   32'd1);
                     check("re_px0",       32'(rgb),   32'(B));
        run_to(6);   check("re_px3",       32'(rgb),   32'(F));
        run_to(642); check("re_vde_last",  32'(vde),   32'd1);
        run_to(643); check("re_vde_off",   32'(vde),   32'd0);
        run_to(658); check("re_hs_pre",    32'(hsync), 32'd1);
        run_to(659); check("re_hs_start",  32'(hsync), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/text_mode_pixel_pipe.md
Name: text_mode_pixel_pipe

Overview:
- Pixel-clock-domain stage inside the MicroBlaze block design, directly upstream of the HDMI TMDS encoder that drives hdmi_tmds_*.
- Generates 640x480@60 timing and renders an 80x30 character screen of 8x16 glyphs.
- Fetches characters from a dual-port VRAM (port B; port A is written by software over AXI) and glyph rows from a font ROM.
- Emits registered 4-bit RGB plus hsync, vsync and vde for the encoder.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_SYNC_START, 656, first hsync-low column
- H_SYNC_END, 752, first column after hsync low
- H_TOTAL, 800, columns per line
- V_ACTIVE, 480, visible lines
- V_SYNC_START, 490, first vsync-low line
- V_SYNC_END, 492, first line after vsync low
- V_TOTAL, 525, lines per frame

Ports:
- Clk  in  1  25 MHz pixel clock
- reset_rtl_0  in  1  asynchronous active-low reset (block designs use active-low reset)
- vram_addr  out  10  VRAM port-B word address; 1-cycle synchronous read
- vram_rdata  in  32  VRAM word; 4 chars, byte 0 (bits 7:0) is leftmost
- font_addr  out  11  font ROM address {code[6:0], glyph_row[3:0]}; 1-cycle synchronous read
- font_rdata  in  8  glyph row; bit 7 is leftmost pixel
- fg_rgb  in  12  foreground colour {R[3:0],G[3:0],B[3:0]}, from AXI control register, quasi-static
- bg_rgb  in  12  background colour, same format
- red  out  4  pixel red
- green  out  4  pixel green
- blue  out  4  pixel blue
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- vde  out  1  video data enable

Behaviour:
- Counters:
  - hc: 0..H_TOTAL-1, increments every Clk.
  - vc: 0..V_TOTAL-1, increments when hc wraps from 799 to 0.
  - Frame wrap: hc=799 and vc=524 -> both go to 0 on the next edge.
- S0 (cycle t): counters at (hc,vc). vram_addr is combinational: (vc[8:4]*20) + hc[9:5]. No underflow; max 599 in the active region. The address is don't-care but still computed in blanking.
- S1 (t+1): vram_rdata valid. Pipe regs hold hc[4:0], vc[3:0], hs, vs and de from S0.
  - Byte select by stage hc[4:3]: char = vram_rdata[8*sel +: 8].
  - font_addr is combinational: {char[6:0], vc[3:0]}.
  - char[7] = invert flag, registered into S2.
- S2 (t+2): font_rdata valid. Pipe regs hold hc[2:0], invert, hs, vs and de.
  - pix = font_rdata[7 - hc[2:0]] ^ invert.
- Output register (visible cycle t+3):
  - {red,green,blue} = de ? (pix ? fg_rgb : bg_rgb) : 12'h000.
  - hsync, vsync and vde are delayed exactly 3 cycles, so they are aligned with RGB.
- Timing decode at S0:
  - hs = ~(hc>=656 && hc<752)
  - vs = ~(vc>=490 && vc<492)
  - de = hc<640 && vc<480
- Total pixel latency is 3 Clk, fixed. No stalls and no back-pressure; the encoder consumes every cycle.
- Reset (async assert, sync release via the flops' natural behaviour):
  - hc=0, vc=0.
  - All pipe hs/vs = 1, de = 0.
  - Outputs: red, green, blue = 0; hsync = 1; vsync = 1; vde = 0.
  - vram_addr = 0 and font_addr = {7'h0, 4'h0} during reset.
- Reset mid-frame: all pipeline contents are discarded immediately. After release, the first frame restarts at (0,0), and the first vde=1 appears 3 cycles after the first post-reset edge.
- fg_rgb/bg_rgb changes take effect at the output register with no synchronisation; tearing within a frame is acceptable.
- Bits 7 of glyph code are never used for addressing (128-glyph ROM).

Test Plan:
- Reset:
  - Stimulus: hold reset_rtl_0=0 for 5 cycles, then release.
  - Required: hsync=1, vsync=1, vde=0, RGB=0 while held. First vde=1 at cycle 3 after release. vde stays high for exactly 640 consecutive cycles.
- Frame timing:
  - Stimulus: run 2 frames.
  - Required: hsync low for 96 cycles starting 659 cycles after line start (656+3); line period 800. vsync low for exactly 1600 cycles per frame; frame period 420000 cycles.
- Glyph render:
  - Stimulus: VRAM word 0 = 32'h00000041; font model row 0 of 'A' = 8'h18; fg=12'hFFF, bg=12'h00F.
  - Required: line 0 pixels 0..7 = B,B,B,F,F,B,B,B (F=FFF, B=00F). vram_addr=0 and font_addr=11'h410 are presented in the correct cycles.
- Invert and byte select:
  - Stimulus: word 1 = 32'h0000C100 (byte 1 = 0xC1).
  - Required: pixels 40..47 on line 0 render 'A' row 0 inverted: F,F,F,B,B,F,F,F.
- Address arithmetic at screen end:
  - Stimulus: observe (hc=639, vc=479).
  - Required: vram_addr=599, font_addr row=4'hF. Last active pixel comes from byte 3 bit 0.
- Reset mid-frame:
  - Stimulus: assert reset at hc=300, vc=200 for 2 cycles.
  - Required: outputs go to reset values asynchronously within the same cycle. After release, counters restart at (0,0) and timing matches the first-frame checks.
